// File: rtl/coin_bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : coin_bcd_display_driver
// Description : Binary coin total to 2-digit multiplexed 7-segment display,
//               using a sequential shift-add-3 binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_bcd_display_driver #(
    parameter int SCAN_DIV = 100_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       over_range,
    output logic       busy
);

    localparam int         c_CNT_W   = $clog2(SCAN_DIV);
    localparam logic [7:0] c_SEG_DASH  = 8'b11111101;
    localparam logic [7:0] c_SEG_BLANK = 8'b11111111;
    localparam logic [7:0] c_SEG_ZERO  = 8'b00000011;
    localparam logic [7:0] c_SEG_BAD   = 8'b01100000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_force;
    logic [7:0]    r_shreg;
    logic [7:0]    r_cap_val;
    logic [7:0]    r_last_val;
    logic [11:0]   r_acc;
    logic [2:0]    r_bit_cnt;

    logic [c_CNT_W-1:0] r_scan_cnt;
    logic               r_dsel;

    logic [11:0]   w_adj;
    logic          w_tick;
    logic [3:0]    w_digit;
    logic [7:0]    w_seg_next;

    function automatic logic [7:0] f_encode(input logic [3:0] d);
        case (d)
            4'd0:    f_encode = 8'b00000011;
            4'd1:    f_encode = 8'b10011111;
            4'd2:    f_encode = 8'b00100101;
            4'd3:    f_encode = 8'b00001101;
            4'd4:    f_encode = 8'b10011001;
            4'd5:    f_encode = 8'b01001001;
            4'd6:    f_encode = 8'b01000001;
            4'd7:    f_encode = 8'b00011111;
            4'd8:    f_encode = 8'b00000001;
            4'd9:    f_encode = 8'b00001001;
            default: f_encode = c_SEG_BAD;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble ahead of the shift
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                      (r_acc[gi*4 +: 4] + 4'd3) :
                                      r_acc[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_force    <= 1'b1;
            r_shreg    <= 8'd0;
            r_cap_val  <= 8'd0;
            r_last_val <= 8'd0;
            r_acc      <= 12'd0;
            r_bit_cnt  <= 3'd0;
            bcd_tens   <= 4'd0;
            bcd_ones   <= 4'd0;
            over_range <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_force || (value != r_last_val)) begin
                        r_shreg   <= value;
                        r_cap_val <= value;
                        r_acc     <= 12'd0;
                        r_bit_cnt <= 3'd0;
                        r_force   <= 1'b0;
                        r_state   <= S_SHIFT;
                        busy      <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    {r_acc, r_shreg} <= {w_adj, r_shreg} << 1;
                    r_bit_cnt        <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_tens   <= r_acc[7:4];
                    bcd_ones   <= r_acc[3:0];
                    over_range <= (r_acc[11:8] != 4'd0);
                    r_last_val <= r_cap_val;
                    r_state    <= S_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign w_tick = (r_scan_cnt == c_CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_dsel     <= 1'b0;
        end else begin
            if (w_tick) begin
                r_scan_cnt <= '0;
                r_dsel     <= ~r_dsel;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    assign an      = r_dsel ? 4'b1101 : 4'b1110;
    assign w_digit = r_dsel ? bcd_tens : bcd_ones;

    always_comb begin
        w_seg_next = f_encode(w_digit);
        if (over_range) begin
            w_seg_next = c_SEG_DASH;
        end else if (r_dsel && (bcd_tens == 4'd0) && BLANK_LZ) begin
            w_seg_next = c_SEG_BLANK;
        end
    end

    // Segments lag the anode select by one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg <= c_SEG_ZERO;
        end else begin
            seg <= w_seg_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coin_bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_bcd_display_driver
// Description : Directed self-checking bench for coin_bcd_display_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_bcd_display_driver;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       over_range;
    logic       busy;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] c_S0    = 8'b00000011;
    localparam logic [7:0] c_S5    = 8'b01001001;
    localparam logic [7:0] c_S6    = 8'b01000001;
    localparam logic [7:0] c_S7    = 8'b00011111;
    localparam logic [7:0] c_S9    = 8'b00001001;
    localparam logic [7:0] c_BLANK = 8'b11111111;
    localparam logic [7:0] c_DASH  = 8'b11111101;

    coin_bcd_display_driver #(
        .SCAN_DIV (4),
        .BLANK_LZ (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .an         (an),
        .seg        (seg),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .over_range (over_range),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Starts a conversion of v from IDLE and checks busy length and digits
    task automatic run_conv(input string tag, input logic [7:0] v,
                            input logic [3:0] pt, input logic [3:0] po,
                            input logic [3:0] et, input logic [3:0] eo,
                            input logic eov);
        int n;
        value = v;
        tick();
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_hold_tens"}, bcd_tens, pt);
        chk({tag, "_hold_ones"}, bcd_ones, po);
        n = 1;
        for (int i = 0; i < 40 && busy; i++) begin
            tick();
            if (busy) n++;
        end
        chk({tag, "_busy_len"}, n, 9);
        chk({tag, "_tens"}, bcd_tens, et);
        chk({tag, "_ones"}, bcd_ones, eo);
        chk({tag, "_over"}, over_range, eov);
    endtask

    // Checks the segment pattern shown for the ones and the tens digit
    task automatic show_check(input string tag, input logic [7:0] eo, input logic [7:0] et);
        int k;
        k = 0;
        while (an !== 4'b1110 && k < 20) begin tick(); k++; end
        tick();
        chk({tag, "_seg_ones"}, seg, eo);
        k = 0;
        while (an !== 4'b1101 && k < 20) begin tick(); k++; end
        chk({tag, "_an_found"}, (k < 20), 1);
        tick();
        chk({tag, "_seg_tens"}, seg, et);
    endtask

    initial begin
        int run;
        bit first;
        logic [3:0] prev_an;

        rst   = 1'b0;
        value = 8'd0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_tens", bcd_tens, 0);
        chk("rst_ones", bcd_ones, 0);
        chk("rst_over", over_range, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, c_S0);

        rst = 1'b1;
        run_conv("v0", 8'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        show_check("v0", c_S0, c_BLANK);

        run_conv("v75", 8'd75, 4'd0, 4'd0, 4'd7, 4'd5, 1'b0);
        show_check("v75", c_S5, c_S7);

        run_conv("v99", 8'd99, 4'd7, 4'd5, 4'd9, 4'd9, 1'b0);
        show_check("v99", c_S9, c_S9);

        run_conv("v100", 8'd100, 4'd9, 4'd9, 4'd0, 4'd0, 1'b1);
        show_check("v100", c_DASH, c_DASH);

        run_conv("v255", 8'd255, 4'd0, 4'd0, 4'd5, 4'd5, 1'b1);
        show_check("v255", c_DASH, c_DASH);

        // 20 captured, then value moves to 45 while shifting
        value = 8'd20;
        tick();
        tick();
        tick();
        value = 8'd45;
        repeat (7) tick();
        chk("chg_first_busy", busy, 0);
        chk("chg_first_tens", bcd_tens, 2);
        chk("chg_first_ones", bcd_ones, 0);
        chk("chg_first_over", over_range, 0);
        tick();
        chk("chg_recapture", busy, 1);
        repeat (8) tick();
        chk("chg_mid_busy", busy, 1);
        chk("chg_mid_tens", bcd_tens, 2);
        tick();
        chk("chg_second_busy", busy, 0);
        chk("chg_second_tens", bcd_tens, 4);
        chk("chg_second_ones", bcd_ones, 5);

        // Reset in the middle of converting 60
        value = 8'd60;
        tick();
        tick();
        tick();
        tick();
        chk("abort_pre_busy", busy, 1);
        rst = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_tens", bcd_tens, 0);
        chk("abort_ones", bcd_ones, 0);
        chk("abort_over", over_range, 0);
        chk("abort_an", an, 4'b1110);
        chk("abort_seg", seg, c_S0);
        rst = 1'b1;
        run_conv("v60", 8'd60, 4'd0, 4'd0, 4'd6, 4'd0, 1'b0);
        show_check("v60", c_S0, c_S6);

        // Scan period with a steady value
        prev_an = an;
        run     = 0;
        first   = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("scan_an_hi", an[3:2], 2'b11);
            if (an !== prev_an) begin
                if (!first) chk("scan_period", run, 4);
                first   = 1'b0;
                run     = 1;
                prev_an = an;
            end else begin
                run++;
            end
        end
        chk("scan_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
